// File: rtl/serial_fsm_sequencer_pkg.sv
// Shared definitions for the serial sequence-detector controller.
package serial_fsm_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Width of the per-word cycle index; covers WIDTH shift cycles plus Y_LAT drain cycles.
    function automatic int unsigned idx_bits(input int unsigned width, input int unsigned y_lat);
        return $clog2(width + y_lat + 1);
    endfunction

endpackage

// File: rtl/serial_fsm_sequencer_if.sv
// Producer-side handshake and result bus of the serial sequencer.
interface serial_fsm_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hit_map;
    logic [CNT_W-1:0] hit_count;

    modport master (
        output start, data_in,
        input  busy, done, hit_map, hit_count
    );

    modport slave (
        input  start, data_in,
        output busy, done, hit_map, hit_count
    );
endinterface

// File: rtl/serial_fsm_sequencer_shift_reg.sv
// Load/shift-left register feeding the detector MSB-first.
module seq_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);
    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = shreg[WIDTH-1];
endmodule

// File: rtl/serial_fsm_sequencer.sv
// Drives a 1-bit sequence detector with a parallel word and collects its per-bit Y responses.
module serial_fsm_sequencer
    import serial_fsm_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned Y_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_fsm_sequencer_if.slave  host,
    output logic                   fsm_reset,
    output logic                   x_out,
    input  logic                   y_in
);
    localparam int unsigned IDX_W = idx_bits(WIDTH, Y_LAT);
    localparam logic [IDX_W-1:0] LAST_SHIFT = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_CYC   = IDX_W'(WIDTH + Y_LAT - 1);
    localparam logic [IDX_W-1:0] FIRST_SMP  = IDX_W'(Y_LAT);
    localparam logic [IDX_W-1:0] POS_BASE   = IDX_W'(WIDTH + Y_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [IDX_W-1:0] cyc;
    logic             sample;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] hit_map;
    logic [CNT_W-1:0] hit_count;
    logic             msb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (host.start) begin
                    accept     = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (cyc == LAST_SHIFT) begin
                    state_next = (Y_LAT == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cyc == LAST_CYC) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (host.start) begin
                    accept     = 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // cyc counts from the first SHIFT cycle; sample k lands at cyc = k + Y_LAT.
    always_comb begin
        sample   = 1'b0;
        bit_mask = '0;
        if ((state == ST_SHIFT || state == ST_DRAIN) && cyc >= FIRST_SMP) begin
            sample   = y_in;
            bit_mask = WIDTH'(1) << (POS_BASE - cyc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc       <= '0;
            hit_map   <= '0;
            hit_count <= '0;
        end else begin
            if (accept) begin
                hit_map   <= '0;
                hit_count <= '0;
            end
            if (state == ST_LOAD) begin
                cyc <= '0;
            end else if (state == ST_SHIFT || state == ST_DRAIN) begin
                cyc <= cyc + IDX_W'(1);
            end
            if (sample) begin
                hit_map <= hit_map | bit_mask;
                if (hit_count != CNT_MAX) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
            end
        end
    end

    seq_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (state == ST_SHIFT),
        .data  (host.data_in),
        .msb   (msb)
    );

    assign fsm_reset      = (state == ST_LOAD);
    assign x_out          = (state == ST_SHIFT) && msb;
    assign host.busy      = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_DRAIN);
    assign host.done      = (state == ST_DONE);
    assign host.hit_map   = hit_map;
    assign host.hit_count = hit_count;
endmodule

// File: tb/tb_serial_fsm_sequencer.sv
// Directed bench for serial_fsm_sequencer with an "11" overlap detector model and result scoreboard.
`timescale 1ns/1ps
module tb_serial_fsm_sequencer;
    import serial_fsm_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_fsm_sequencer_if #(.WIDTH(8),  .CNT_W(4)) bus8 ();
    serial_fsm_sequencer_if #(.WIDTH(16), .CNT_W(3)) bus16 ();

    logic fr8, x8, fr16, x16;
    logic y8 = 1'b0, p8 = 1'b0, y16 = 1'b0, p16 = 1'b0;

    serial_fsm_sequencer #(.WIDTH(8), .CNT_W(4), .Y_LAT(1)) dut8 (
        .clk(clk), .reset(reset), .host(bus8), .fsm_reset(fr8), .x_out(x8), .y_in(y8)
    );
    serial_fsm_sequencer #(.WIDTH(16), .CNT_W(3), .Y_LAT(1)) dut16 (
        .clk(clk), .reset(reset), .host(bus16), .fsm_reset(fr16), .x_out(x16), .y_in(y16)
    );

    always @(posedge clk) begin
        if (fr8) begin p8 <= 1'b0; y8 <= 1'b0; end
        else begin p8 <= x8; y8 <= x8 & p8; end
    end
    always @(posedge clk) begin
        if (fr16) begin p16 <= 1'b0; y16 <= 1'b0; end
        else begin p16 <= x16; y16 <= x16 & p16; end
    end

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [15:0] map;
        int          cnt;
        int          accept;
    } exp_t;
    exp_t q8[$];
    exp_t q16[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Overlapping "11": response for bit i is data[i] & data[i+1] (the previously sent bit).
    function automatic logic [7:0] model_map8(input logic [7:0] w);
        return w & (w >> 1);
    endfunction

    function automatic int popcount8(input logic [7:0] w);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(w[i]);
        return n;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (bus8.done === 1'b1) begin
            exp_t e;
            if (q8.size() == 0) begin
                chk("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("hit_map8", 32'(bus8.hit_map), 32'(e.map[7:0]));
                chk("hit_count8", 32'(bus8.hit_count), 32'(e.cnt));
                chk("latency8", 32'(cyc_cnt - e.accept), 32'd10);
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (bus16.done === 1'b1) begin
            exp_t e;
            if (q16.size() == 0) begin
                chk("done16_unexpected", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                chk("hit_map16", 32'(bus16.hit_map), 32'(e.map));
                chk("hit_count16", 32'(bus16.hit_count), 32'(e.cnt));
                chk("latency16", 32'(cyc_cnt - e.accept), 32'd18);
            end
        end
    end

    task automatic send8(input logic [7:0] d, input logic [7:0] m, input int c);
        bus8.start   = 1'b1;
        bus8.data_in = d;
        q8.push_back('{map: 16'(m), cnt: c, accept: cyc_cnt + 1});
        tick();
        bus8.start   = 1'b0;
        bus8.data_in = 8'($urandom);
    endtask

    task automatic wait_done8(input int maxc);
        int n = 0;
        while (bus8.done !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        if (bus8.done !== 1'b1) chk("timeout8", 32'd0, 32'd1);
    endtask

    task automatic wait_done16(input int maxc);
        int n = 0;
        while (bus16.done !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        if (bus16.done !== 1'b1) chk("timeout16", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] a;

        bus8.start    = 1'b0;
        bus8.data_in  = '0;
        bus16.start   = 1'b0;
        bus16.data_in = '0;
        reset = 1'b1;
        #30;
        reset = 1'b0;

        // 1) reset state and quiet idle
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_fsm_reset", 32'(fr8), 32'd0);
        chk("rst_x_out", 32'(x8), 32'd0);
        chk("rst_hit_map", 32'(bus8.hit_map), 32'd0);
        chk("rst_hit_count", 32'(bus8.hit_count), 32'd0);
        chk("rst_state", 32'(dut8.state), 32'(ST_IDLE));
        chk("rst_hit_count16", 32'(bus16.hit_count), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_done", 32'(bus8.done), 32'd0);
            chk("idle_busy", 32'(bus8.busy), 32'd0);
        end

        // 2) single word, bit-level check of the serial stream
        d = 8'b0111_1001;
        send8(d, 8'b0011_1000, 3);
        chk("load_fsm_reset", 32'(fr8), 32'd1);
        chk("load_busy", 32'(bus8.busy), 32'd1);
        chk("load_x_out", 32'(x8), 32'd0);
        chk("load_state", 32'(dut8.state), 32'(ST_LOAD));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("shift_x_out", 32'(x8), 32'(d[7-k]));
            chk("shift_fsm_reset", 32'(fr8), 32'd0);
            chk("shift_busy", 32'(bus8.busy), 32'd1);
        end
        tick();
        chk("drain_x_out", 32'(x8), 32'd0);
        chk("drain_busy", 32'(bus8.busy), 32'd1);
        tick();
        chk("done_pulse", 32'(bus8.done), 32'd1);
        chk("done_busy", 32'(bus8.busy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(bus8.done), 32'd0);
        tick();
        tick();
        chk("held_hit_map", 32'(bus8.hit_map), 32'h38);
        chk("held_hit_count", 32'(bus8.hit_count), 32'd3);

        // 3) back-to-back words, second accepted on the done cycle
        send8(8'hFF, 8'h7F, 7);
        wait_done8(20);
        bus8.start   = 1'b1;
        bus8.data_in = 8'h00;
        q8.push_back('{map: 16'h0, cnt: 0, accept: cyc_cnt + 1});
        tick();
        bus8.start = 1'b0;
        chk("b2b_busy", 32'(bus8.busy), 32'd1);
        chk("b2b_fsm_reset", 32'(fr8), 32'd1);
        chk("b2b_cleared", 32'(bus8.hit_count), 32'd0);
        wait_done8(20);
        tick();

        // 4) start during SHIFT is ignored
        a = 8'hCD;
        send8(a, model_map8(a), popcount8(model_map8(a)));
        tick();
        tick();
        bus8.start   = 1'b1;
        bus8.data_in = 8'h3C;
        tick();
        bus8.start = 1'b0;
        wait_done8(20);
        for (int i = 0; i < 4; i++) tick();
        chk("ignored_start_queue", 32'(q8.size()), 32'd0);

        // 5) reset in the 4th SHIFT cycle aborts with results cleared
        send8(8'hFF, 8'h7F, 7);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_state_shift", 32'(dut8.state), 32'(ST_SHIFT));
        chk("abort_partial_count", 32'(bus8.hit_count), 32'd1);
        reset = 1'b1;
        q8.delete();
        tick();
        reset = 1'b0;
        chk("abort_state", 32'(dut8.state), 32'(ST_IDLE));
        chk("abort_x_out", 32'(x8), 32'd0);
        chk("abort_busy", 32'(bus8.busy), 32'd0);
        chk("abort_hit_count", 32'(bus8.hit_count), 32'd0);
        chk("abort_hit_map", 32'(bus8.hit_map), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_done", 32'(bus8.done), 32'd0);
        end

        // 6) 16-bit instance, count saturates at 7
        bus16.start   = 1'b1;
        bus16.data_in = 16'hFFFF;
        q16.push_back('{map: 16'h7FFF, cnt: 7, accept: cyc_cnt + 1});
        tick();
        bus16.start   = 1'b0;
        bus16.data_in = 16'h1234;
        wait_done16(30);
        tick();
        tick();
        chk("sat_held", 32'(bus16.hit_count), 32'd7);

        chk("queue8_empty", 32'(q8.size()), 32'd0);
        chk("queue16_empty", 32'(q16.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
